// File: rtl/series_sum_pkg.sv
// Shared types for the series sum engine: series select and FSM state encodings.
package series_sum_pkg;

    // Series selected by the 2-bit mode input; RSVD is treated as SUM_I.
    typedef enum logic [1:0] {
        SUM_I   = 2'b00,
        SUM_SQ  = 2'b01,
        SUM_ODD = 2'b10,
        RSVD    = 2'b11
    } mode_t;

    // Run-control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/series_term_gen.sv
// Combinational term generator: maps the current index i and series mode to
// the term added on this cycle. This is the only place the mode is decoded.
import series_sum_pkg::*;

module series_term_gen #(
    parameter int N_W = 4
) (
    input  logic [N_W-1:0]   i,
    input  logic [1:0]       mode,
    output logic [2*N_W-1:0] term
);

    localparam logic [2*N_W-1:0] ONE = {{(2*N_W-1){1'b0}}, 1'b1};

    logic [2*N_W-1:0] i_ext;

    assign i_ext = {{N_W{1'b0}}, i};

    // Select the term; i=0 never reaches the accumulator, so the odd-series
    // wrap at i=0 is harmless.
    always_comb begin
        term = i_ext;
        case (mode_t'(mode))
            SUM_SQ:  term = i_ext * i_ext;
            SUM_ODD: term = (i_ext << 1) - ONE;
            default: term = i_ext;
        endcase
    end

endmodule

// File: rtl/series_sum_engine.sv
// Series accumulator: sums term(i) for i = n down to 1, one term per clock,
// saturating at all-ones with a sticky overflow flag.
//
// Handshake: start is sampled only in IDLE; the accepting edge latches n and
// mode. busy is high for the n+1 cycles of RUN, then done pulses for exactly
// one cycle (DONE) while sum/overflow are final. start outside IDLE is
// dropped, not queued. sum/overflow hold until the next accepted start.
import series_sum_pkg::*;

module series_sum_engine #(
    parameter int N_W = 4,
    parameter int S_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [1:0]     mode,
    output logic           busy,
    output logic           done,
    output logic [S_W-1:0] sum,
    output logic           overflow,
    output logic [1:0]     dbg_state
);

    generate
        if (S_W < 2 * N_W) begin : g_bad_width
            $error("series_sum_engine: S_W must be at least 2*N_W");
        end
    endgenerate

    state_t           state;
    state_t           state_nx;
    logic [N_W-1:0]   cnt;
    logic [1:0]       mode_q;
    logic [2*N_W-1:0] term;
    logic [S_W:0]     acc;

    series_term_gen #(.N_W(N_W)) u_term (
        .i    (cnt),
        .mode (mode_q),
        .term (term)
    );

    // One extra bit on the add exposes the carry used for saturation.
    assign acc = {1'b0, sum} + {{(S_W + 1 - 2 * N_W){1'b0}}, term};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: RUN exits once the down-counter reaches zero.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch run parameters on accept, then accumulate and count down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mode_q   <= 2'b00;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= n;
                        mode_q   <= mode;
                        sum      <= '0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        if (acc[S_W]) begin
                            sum      <= '1;
                            overflow <= 1'b1;
                        end else begin
                            sum <= acc[S_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_series_sum_engine.sv
// Directed bench for series_sum_engine: a default-width instance and a narrow
// (S_W=8) instance that exercises saturation.
module tb_series_sum_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;
    logic [3:0] n;
    logic [1:0] mode;

    logic        start0, start1;
    logic        busy0, done0, ovf0;
    logic [15:0] sum0;
    logic [1:0]  st0;
    logic        busy1, done1, ovf1;
    logic [7:0]  sum1;
    logic [1:0]  st1;

    logic        o_busy, o_done, o_ovf;
    logic [15:0] o_sum;

    int n_cmp = 0;
    int n_err = 0;

    // Clock.
    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_ovf  = sel ? ovf1 : ovf0;
    assign o_sum  = sel ? {8'h00, sum1} : sum0;

    series_sum_engine #(.N_W(4), .S_W(16)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .n         (n),
        .mode      (mode),
        .busy      (busy0),
        .done      (done0),
        .sum       (sum0),
        .overflow  (ovf0),
        .dbg_state (st0)
    );

    series_sum_engine #(.N_W(4), .S_W(8)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .n         (n),
        .mode      (mode),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .overflow  (ovf1),
        .dbg_state (st1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one run and check latency, busy length and the final result.
    task automatic run(input string name, input logic s, input logic [3:0] nv,
                       input logic [1:0] mv, input logic [15:0] exp_sum,
                       input logic exp_ovf, input int glitch_at);
        int edges;
        int busy_cnt;
        bit seen;
        sel = s;
        @(negedge clk);
        start = 1'b1;
        n     = nv;
        mode  = mv;
        @(posedge clk);
        edges    = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (edges < 100 && !seen) begin
            @(negedge clk);
            start = (edges == glitch_at);
            if (edges == glitch_at) begin
                n    = ~nv;
                mode = ~mv;
            end
            if (o_done) begin
                seen = 1'b1;
            end else begin
                if (o_busy) busy_cnt++;
                @(posedge clk);
                edges++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check({name, ".timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, ".latency"}, edges, nv + 1);
            check({name, ".busy_cycles"}, busy_cnt, nv + 1);
            check({name, ".sum"}, o_sum, exp_sum);
            check({name, ".ovf"}, o_ovf, exp_ovf);
            check({name, ".busy_at_done"}, o_busy, 1'b0);
        end
    endtask

    // One cycle after the done pulse: done low, result held.
    task automatic hold(input string name, input logic [15:0] exp_sum, input logic exp_ovf);
        @(negedge clk);
        check({name, ".done_drop"}, o_done, 1'b0);
        check({name, ".sum_hold"}, o_sum, exp_sum);
        check({name, ".ovf_hold"}, o_ovf, exp_ovf);
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        n     = 4'd0;
        mode  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", busy0, 1'b0);
        check("rst.done", done0, 1'b0);
        check("rst.sum", sum0, 16'd0);
        check("rst.ovf", ovf0, 1'b0);
        check("rst.sum_narrow", sum1, 8'd0);
        rst = 1'b0;

        run("n4_i", 1'b0, 4'd4, 2'b00, 16'd10, 1'b0, -1);
        hold("n4_i", 16'd10, 1'b0);
        run("n15_sq", 1'b0, 4'd15, 2'b01, 16'd1240, 1'b0, -1);
        run("n6_odd", 1'b0, 4'd6, 2'b10, 16'd36, 1'b0, -1);
        run("rsvd", 1'b0, 4'd4, 2'b11, 16'd10, 1'b0, -1);
        run("n0", 1'b0, 4'd0, 2'b01, 16'd0, 1'b0, -1);
        run("b2b", 1'b0, 4'd3, 2'b00, 16'd6, 1'b0, -1);
        run("sat", 1'b1, 4'd15, 2'b01, 16'd255, 1'b1, -1);
        hold("sat", 16'd255, 1'b1);
        run("sat_next", 1'b1, 4'd2, 2'b00, 16'd3, 1'b0, -1);
        run("glitch", 1'b0, 4'd5, 2'b00, 16'd15, 1'b0, 2);

        // Reset sampled at edge E3 of an n=10 run.
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        n     = 4'd10;
        mode  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst.partial", sum0, 16'd10);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", busy0, 1'b0);
        check("midrst.sum", sum0, 16'd0);
        check("midrst.done", done0, 1'b0);
        check("midrst.ovf", ovf0, 1'b0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done0) pulses++;
        end
        check("midrst.no_done", pulses, 0);

        // Reset and start together: reset wins and the start is lost.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        n     = 4'd7;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start.busy", busy0, 1'b0);
        @(negedge clk);
        check("rst_start.still_idle", busy0, 1'b0);

        run("after_rst", 1'b0, 4'd10, 2'b00, 16'd55, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/series_sum_engine.md
# series_sum_engine

Parametrised series accumulator that computes the sum of a selectable integer series over i = 1..n. Each run takes one term per clock, under a start/busy/done handshake. It saturates rather than wraps, and reports overflow. It replaces the fixed 4-bit/8-bit sum-of-N datapath and serves as the arithmetic-sequence engine for the counter/adder-based blocks in this design.

## Interface
Parameters:
- N_W, 4, width of the term count n.
- S_W, 16, width of the sum output; must satisfy S_W >= 2*N_W (elaboration error otherwise).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a run; sampled only in IDLE.
- n  in  N_W  number of terms; latched on accepted start.
- mode  in  2  series select; latched on accepted start.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when the sum is final.
- sum  out  S_W  accumulated sum.
- overflow  out  1  sticky saturation flag for the current or last run.

## Operation
- Modes:
  - 00: term = i.
  - 01: term = i*i.
  - 10: term = 2i-1 (odd numbers).
  - 11: reserved, behaves as 00.
- FSM states:
  - IDLE: start=1 → RUN. On the accepting edge, latch n and mode, clear sum and overflow, load counter i=n.
  - RUN: each edge with i≠0 adds term(i) and decrements i. At i=0, go to DONE with no add.
  - DONE: done=1 for this single cycle, then unconditionally → IDLE.
- n=0: RUN is entered with i=0, so no term is added. The result is sum=0 and done follows.
- Term is computed in 2*N_W bits and zero-extended to S_W+1 bits for the add.
- If acc+term > 2^S_W−1, sum saturates to all-ones and overflow=1. Later terms keep sum at all-ones.
- start while busy or in DONE is ignored and not queued.
- sum and overflow hold their values from DONE until the next accepted start.
- rst=1 at any edge, including mid-run: state=IDLE, sum=0, overflow=0, busy=0, done=0, i=0. Any in-progress run is abandoned.
- rst and start in the same cycle: rst wins, and the start is lost.

## Timing
- Reset values: busy=0, done=0, sum=0, overflow=0.
- start accepted at edge E0. busy=1 from after E0 until after edge E(n+1).
- Terms are added at edges E1..En, in order i=n down to 1.
- After edge E(n+1): state DONE, done=1, busy=0, sum final.
- Latency from start to done is n+1 edges for all n, including n=0.
- Between runs, done=0 again one cycle after the pulse. A new start is accepted in the cycle after DONE at the earliest.
- sum is visible mid-run as partial accumulation. It is only guaranteed final while done=1 and afterwards.

## Structure
- Package series_sum_pkg holds:
  - the mode enum: SUM_I, SUM_SQ, SUM_ODD, RSVD;
  - the FSM state enum: IDLE, RUN, DONE.
- Sub-module series_term_gen: purely combinational, i and mode → term (2*N_W bits). It is the only place mode is decoded.
- The top holds the FSM, the down-counter, the saturating accumulator and the output registers.

## Test plan
- Default params, mode=00, n=4, start pulse → done exactly 5 edges after start, sum=10, overflow=0, busy high for 5 cycles.
- mode=01, n=15 → sum=1240 after 16 edges, overflow=0. mode=10, n=6 → sum=36.
- n=0, any mode → done 1 edge after start, sum=0. Then back-to-back start with n=3 mode=00 in the cycle after done → sum=6.
- Instance N_W=4, S_W=8, mode=01, n=15 → sum=255, overflow=1, done on schedule. Next run n=2 mode=00 → sum=3, overflow=0.
- start re-asserted mid-run with different n and mode → ignored, and the original result is unchanged (n=5 mode=00 → 15).
- rst asserted at edge E3 of an n=10 run → next cycle busy=0, sum=0, done never pulses. A subsequent start with n=10 mode=00 → sum=55.
